// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: iterative multiply/divide sequencer for MUL, MULHU, DIVU and REMU.
// It has no adder of its own. Each RUN cycle it drives the shared ALU (a, b, fn)
// and consumes the ALU's out/cf. Every operation takes one iteration per bit.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, rs1, rs2 request; op/operands are latched when start is seen in IDLE
//                       op: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   busy, done, result  busy in RUN; done pulses one cycle; result holds until next done
//   alu_a, alu_b,       operands and function code sent to the shared ALU
//   alu_shamt, alu_fn   (alu_shamt is always zero)
//   alu_out, alu_cf     ALU sum/difference and carry (SUB: cf=1 means a>=b unsigned)
//
// Optional feature: define MDU_EARLY_OUT_EN to finish trivial operands at once.
// The trivial cases are a multiply with a zero operand and a divide by zero.
// They go IDLE->DONE without any RUN cycle.

`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif

module alu_mdu_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [4:0]      alu_shamt,
   output logic [3:0]      alu_fn,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_cf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        op_q;
   logic [XLEN-1:0]   dsr;       // multiplicand / divisor
   logic [XLEN-1:0]   hi, lo;    // MUL: {hi,lo} product; DIV: hi=rem, lo=quot
   logic [XLEN-1:0]   hi_nxt, lo_nxt, t;
   logic [CNT_W-1:0]  count;
   logic              take, last, early;
   logic [XLEN-1:0]   early_res;

`ifdef MDU_EARLY_OUT_EN
   assign early     = op[1] ? (rs2 == '0) : ((rs1 == '0) || (rs2 == '0));
   assign early_res = op[1] ? (op[0] ? rs1 : '1) : '0;
`else
   assign early     = 1'b0;
   assign early_res = '0;
`endif

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign alu_shamt = '0;
   assign last      = (count == CNT_W'(XLEN-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      alu_fn    = `ALU_ADD;
      alu_a     = '0;
      alu_b     = '0;
      t         = {hi[XLEN-2:0], lo[XLEN-1]};
      take      = 1'b0;
      hi_nxt    = hi;
      lo_nxt    = lo;
      case (state)
         IDLE: if (start) state_nxt = early ? DONE : RUN;
         RUN: begin
            if (op_q[1]) begin
               // Restoring divide step. hi[XLEN-1] is the bit shifted out of t;
               // when it is set, {spare,t} >= divisor regardless of alu_cf.
               alu_fn = `ALU_SUB;
               alu_a  = t;
               alu_b  = dsr;
               take   = hi[XLEN-1] | alu_cf;
               hi_nxt = take ? alu_out : t;
               lo_nxt = {lo[XLEN-2:0], take};
            end else begin
               // Shift-add multiply step: the 33-bit sum is shifted right into {hi,lo}.
               alu_a = hi;
               alu_b = lo[0] ? dsr : '0;
               {hi_nxt, lo_nxt} = {alu_cf, alu_out, lo[XLEN-1:1]};
            end
            if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         dsr    <= '0;
         hi     <= '0;
         lo     <= '0;
         count  <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_q  <= op;
               dsr   <= rs2;
               hi    <= '0;
               lo    <= rs1;
               count <= '0;
               if (early) result <= early_res;
            end
            RUN: begin
               hi    <= hi_nxt;
               lo    <= lo_nxt;
               count <= count + 1'b1;
               // op[0] selects the high half (MULHU) or remainder (REMU).
               if (last) result <= op_q[0] ? hi_nxt : lo_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Testbench for alu_mdu_seq. It models the shared ALU and checks results, latency
// and busy duration against directed vectors and a reference model. It also checks
// the start-during-RUN and reset-abort cases.

`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif

module tb_alu_mdu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic        busy, done;
   logic [31:0] result, alu_a, alu_b, alu_out;
   logic [4:0]  alu_shamt;
   logic [3:0]  alu_fn;
   logic        alu_cf;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mdu_seq #(.XLEN(32), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
      .busy(busy), .done(done), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_fn(alu_fn),
      .alu_out(alu_out), .alu_cf(alu_cf)
   );

   always #5 clk = ~clk;

   // Shared ALU model
   always_comb begin
      logic [32:0] s;
      s = '0;
      if (alu_fn == `ALU_ADD)      s = {1'b0, alu_a} + {1'b0, alu_b};
      else if (alu_fn == `ALU_SUB) s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      alu_out = s[31:0];
      alu_cf  = s[32];
   end

   function automatic logic [31:0] ref_model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit exp_early(logic [1:0] o, logic [31:0] a, logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
      return o[1] ? (b == 0) : (a == 0 || b == 0);
`else
      return (o == 2'b00 && a == 32'h1 && b == 32'h1 && o[0]);  // always 0
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one op and wait for done. lat counts edges from the start edge (inclusive).
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bc);
      @(negedge clk);
      start = 1'b1; op = o; rs1 = a; rs2 = b;
      lat = 0; bc = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = 1'b0;
         if (busy) bc++;
      end while (!done && lat < 100);
      res = result;
   endtask

   typedef struct {
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] res;
      int lat, bc, dones;
      bit e;

      vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         "mul_7x6"};
      vecs[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  "mulhu_max"};
      vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  "mul_max"};
      vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd14,         "divu_100_7"};
      vecs[4]  = '{2'b11, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
      vecs[5]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          "divu_big"};
      vecs[6]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "remu_big"};
      vecs[7]  = '{2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF,  "divu_by0"};
      vecs[8]  = '{2'b11, 32'd5,          32'd0,          32'd5,          "remu_by0"};
      vecs[9]  = '{2'b00, 32'd0,          32'd123,        32'd0,          "mul_zero"};
      vecs[10] = '{2'b01, 32'h1234_5678,  32'h10,         32'h1,          "mulhu_small"};
      vecs[11] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  "divu_by1"};

      // Reset state
      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_fn", {28'b0, alu_fn}, {28'b0, `ALU_ADD});
      check("rst_alu_a", alu_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].o, vecs[i].a, vecs[i].b, res, lat, bc);
         e = exp_early(vecs[i].o, vecs[i].a, vecs[i].b);
         check({vecs[i].name, "_result"}, res, vecs[i].exp);
         check({vecs[i].name, "_latency"}, lat, e ? 32'd1 : 32'd33);
         check({vecs[i].name, "_busy"}, bc, e ? 32'd0 : 32'd32);
      end
      check("idle_shamt", {27'b0, alu_shamt}, 32'd0);

      // Randomized operations vs reference model
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         o = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 :
             ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFF) : $urandom;
         run_op(o, a, b, res, lat, bc);
         check("rand_result", res, ref_model(o, a, b));
         check("rand_latency", lat, exp_early(o, a, b) ? 32'd1 : 32'd33);
      end

      // start held high during RUN: exactly one done, result of the first op
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs1 = 32'd7; rs2 = 32'd6;
      dones = 0; lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) begin
            dones++;
            start = 1'b0;
         end else begin
            op = 2'($urandom_range(0, 3)); rs1 = $urandom; rs2 = $urandom;
         end
      end while (!done && lat < 100);
      check("hold_start_result", result, 32'd42);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("hold_start_dones", dones, 32'd1);

      // Reset in the middle of RUN
      @(negedge clk);
      start = 1'b1; op = 2'b10; rs1 = 32'd1000; rs2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) @(negedge clk);
      check("pre_abort_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 32'd0);
      run_op(2'b11, 32'd1000, 32'd3, res, lat, bc);
      check("post_abort_result", res, 32'd1);
      check("post_abort_latency", lat, 32'd33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
